// File: rtl/display_scanner_pkg.sv
// display_pkg: shared types and constants for the display_scanner slice.
//   state_e   - scanner FSM states
//   R/G/B_LSB - bit offsets of the colour fields inside a 24-bit pixel word
//   PIXEL_W   - pixel word width
//   rgb_bits  - picks one BCM plane bit from each colour field of a pixel
package display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_e;

    localparam int R_LSB   = 16;
    localparam int G_LSB   = 8;
    localparam int B_LSB   = 0;
    localparam int PIXEL_W = 24;

    // Returns {r, g, b} bits of bit-plane p of pixel word w.
    function automatic logic [2:0] rgb_bits(logic [PIXEL_W-1:0] w, logic [2:0] p);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = w[R_LSB +: 8];
        g = w[G_LSB +: 8];
        b = w[B_LSB +: 8];
        return {r[p], g[p], b[p]};
    endfunction

endpackage

// File: rtl/display_scanner_bcm_timer.sv
// display_bcm_timer: loadable down-counter that times the DISPLAY (oe_n low)
// period of one BCM bit plane.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - load the period for 'plane' (asserted in the LATCH cycle)
//   run          - count down (asserted while in DISPLAY)
//   plane        - current bit plane
//   brightness   - global dimming factor (only with DISPLAY_SCANNER_BRIGHTNESS_EN)
//   active       - period not yet exhausted (panel may be lit)
//   done         - this is the last DISPLAY cycle
// Optional feature macro: DISPLAY_SCANNER_BRIGHTNESS_EN.
module display_bcm_timer
    import display_pkg::*;
#(
    parameter int bits    = 8,
    parameter int on_unit = 1,
    parameter int PLANE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               run,
    input  logic [PLANE_W-1:0] plane,
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
    input  logic [7:0]         brightness,
`endif
    output logic               active,
    output logic               done
);

    localparam int CNT_W = $clog2((on_unit << (bits - 1)) + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
            cnt_d = CNT_W'(((32'(brightness) + 32'd1) * (32'(on_unit) << plane)) >> 8);
`else
            cnt_d = CNT_W'(32'(on_unit) << plane);
`endif
        end else if (run && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // A zero-length period still occupies one DISPLAY cycle, with the panel dark.
    assign active = (cnt_q != '0);
    assign done   = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/display_scanner.sv
// display_scanner: reads the displayed frame buffer and drives a dual-scan
// HUB75-style panel with binary-code-modulated colour.
//   clk, rst_n          - clock, asynchronous active-low reset
//   enable              - run request, sampled at frame start
//   rrow, rcol / rdata  - memory read port; rdata is registered (1-cycle latency)
//   r0,g0,b0 / r1,g1,b1 - upper / lower half pixel bits
//   addr, sclk, latch, oe_n - panel row address, shift clock, latch, output enable
//   frame_done          - one-cycle pulse once a full frame has been shown
//   brightness          - dimming factor (only with DISPLAY_SCANNER_BRIGHTNESS_EN)
// Optional feature macro: DISPLAY_SCANNER_BRIGHTNESS_EN.
module display_scanner
    import display_pkg::*;
#(
    parameter int rows    = 16,
    parameter int columns = 32,
    parameter int bits    = 8,
    parameter int on_unit = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
    input  logic [7:0]                   brightness,
`endif
    output logic [$clog2(rows)-1:0]      rrow,
    output logic [$clog2(columns)-1:0]   rcol,
    input  logic [23:0]                  rdata,
    output logic                         r0,
    output logic                         g0,
    output logic                         b0,
    output logic                         r1,
    output logic                         g1,
    output logic                         b1,
    output logic [$clog2(rows/2)-1:0]    addr,
    output logic                         sclk,
    output logic                         latch,
    output logic                         oe_n,
    output logic                         frame_done
);

    localparam int ROW_W  = $clog2(rows / 2);
    localparam int RROW_W = $clog2(rows);
    localparam int COL_W  = $clog2(columns);
    localparam int PL_W   = (bits > 1) ? $clog2(bits) : 1;

    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(rows / 2 - 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(columns - 1);
    localparam logic [PL_W-1:0]   LAST_PLANE = PL_W'(bits - 1);
    localparam logic [RROW_W-1:0] HALF       = RROW_W'(rows / 2);

    state_e               state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [PL_W-1:0]      plane_q, plane_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [1:0]           phase_q, phase_d;
    logic [PIXEL_W-1:0]   upper_q, upper_d;
    logic [5:0]           pix_q, pix_d;
    logic [RROW_W-1:0]    rrow_q, rrow_d;
    logic [COL_W-1:0]     rcol_q, rcol_d;
    logic [ROW_W-1:0]     addr_q, addr_d;
    logic                 fd_q, fd_d;
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
    logic [7:0]           bright_q, bright_d;
`endif

    logic                 tmr_load, tmr_run, tmr_active, tmr_done;
    logic [RROW_W-1:0]    rd_row;
    logic [5:0]           shift_pix;

    // Phase 0 reads the upper-half row, later phases the lower-half row.
    assign rd_row    = (phase_q == 2'd0) ? RROW_W'(row_q) : RROW_W'(row_q) + HALF;
    // Upper word was captured in phase 1; lower word is on rdata during phase 2.
    assign shift_pix = {rgb_bits(upper_q, 3'(plane_q)), rgb_bits(rdata, 3'(plane_q))};
    assign tmr_load  = (state_q == LATCH);
    assign tmr_run   = (state_q == DISPLAY);

    display_bcm_timer #(
        .bits    (bits),
        .on_unit (on_unit),
        .PLANE_W (PL_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .run        (tmr_run),
        .plane      (plane_q),
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
        .brightness (bright_q),
`endif
        .active     (tmr_active),
        .done       (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            plane_q  <= '0;
            col_q    <= '0;
            phase_q  <= '0;
            upper_q  <= '0;
            pix_q    <= '0;
            rrow_q   <= '0;
            rcol_q   <= '0;
            addr_q   <= '0;
            fd_q     <= 1'b0;
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
            bright_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            plane_q  <= plane_d;
            col_q    <= col_d;
            phase_q  <= phase_d;
            upper_q  <= upper_d;
            pix_q    <= pix_d;
            rrow_q   <= rrow_d;
            rcol_q   <= rcol_d;
            addr_q   <= addr_d;
            fd_q     <= fd_d;
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
            bright_q <= bright_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        plane_d  = plane_q;
        col_d    = col_q;
        phase_d  = phase_q;
        upper_d  = upper_q;
        pix_d    = pix_q;
        rrow_d   = rrow_q;
        rcol_d   = rcol_q;
        addr_d   = addr_q;
        fd_d     = 1'b0;
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
        bright_d = bright_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = SHIFT;
                    row_d    = '0;
                    plane_d  = '0;
                    col_d    = '0;
                    phase_d  = '0;
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
                    bright_d = brightness;
`endif
                end
            end
            SHIFT: begin
                rrow_d  = rd_row;
                rcol_d  = col_q;
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd1) upper_d = rdata;
                if (phase_q == 2'd2) pix_d = shift_pix;
                if (phase_q == 2'd3) begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = BLANK;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            BLANK: state_d = LATCH;
            LATCH: begin
                state_d = DISPLAY;
                addr_d  = row_q;
            end
            DISPLAY: begin
                if (tmr_done) begin
                    state_d = SHIFT;
                    if (plane_q != LAST_PLANE) begin
                        plane_d = plane_q + PL_W'(1);
                    end else begin
                        plane_d = '0;
                        if (row_q == LAST_ROW) begin
                            // Frame boundary: the only point where enable is honoured.
                            row_d = '0;
                            fd_d  = 1'b1;
                            if (!enable) state_d = IDLE;
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
                            bright_d = brightness;
`endif
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sclk       = 1'b0;
        latch      = 1'b0;
        oe_n       = 1'b1;
        addr       = addr_q;
        rrow       = rrow_q;
        rcol       = rcol_q;
        frame_done = fd_q;
        {r0, g0, b0, r1, g1, b1} = pix_q;
        case (state_q)
            SHIFT: begin
                rrow = rd_row;
                rcol = col_q;
                sclk = (phase_q == 2'd3);
                if (phase_q == 2'd2) {r0, g0, b0, r1, g1, b1} = shift_pix;
            end
            LATCH:   begin
                latch = 1'b1;
                addr  = row_q;
            end
            DISPLAY: oe_n = !tmr_active;
            default: ;
        endcase
    end

endmodule
